// File: rtl/crosswalk_btn_sync.sv
// Pedestrian button conditioner: synchronise, debounce, and turn presses into a
// held crossing request, queuing one press made during a crossing cycle.
module crosswalk_btn_sync #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_W         = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_btn_raw,
  input  logic               i_ack,
  input  logic               i_busy,
  output logic               o_req,
  output logic               o_btn_level,
  output logic               o_pending,
  output logic [COUNT_W-1:0] o_req_count
);

  // state   | meaning
  // IDLE    | no request outstanding
  // REQ     | request held high until the controller acks
  // WAIT    | controller crossing; await busy falling edge
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic               r_s1;
  logic               r_btn_s;
  logic [DB_W-1:0]    r_db_cnt;
  logic               r_btn_level;
  logic               r_busy_d;
  logic [1:0]         r_state;
  logic               r_req;
  logic               r_pending;
  logic [COUNT_W-1:0] r_req_count;

  logic       w_rise;
  logic       w_busy_fall;
  logic [1:0] w_state_nxt;
  logic       w_pending_nxt;
  logic       w_enter_req;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_s1    <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_s1    <= i_btn_raw;
      r_btn_s <= r_s1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_db_cnt    <= '0;
      r_btn_level <= 1'b0;
    end else if (r_btn_s == r_btn_level) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_btn_level <= r_btn_s;
      r_db_cnt    <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  // A rise event is the edge on which the debounced level goes 0 -> 1.
  assign w_rise      = r_btn_s && !r_btn_level && (r_db_cnt == DB_LAST);
  assign w_busy_fall = r_busy_d && !i_busy;

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_enter_req   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_REQ;
          w_enter_req = 1'b1;
        end
      end
      S_REQ: begin
        if (i_ack) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_busy_fall) begin
          if (r_pending || w_rise) begin
            w_state_nxt   = S_REQ;
            w_pending_nxt = 1'b0;
            w_enter_req   = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_rise) begin
          w_pending_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_pending   <= 1'b0;
      r_req_count <= '0;
      r_busy_d    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= (w_state_nxt == S_REQ);
      r_pending <= w_pending_nxt;
      r_busy_d  <= i_busy;
      if (w_enter_req && (r_req_count != {COUNT_W{1'b1}}))
        r_req_count <= r_req_count + COUNT_W'(1);
    end
  end

  assign o_req       = r_req;
  assign o_btn_level = r_btn_level;
  assign o_pending   = r_pending;
  assign o_req_count = r_req_count;

endmodule

// File: tb/tb_crosswalk_btn_sync.sv
// Directed bench for crosswalk_btn_sync: debounce latency, glitch rejection,
// request/ack/busy handshake, queued press, counter saturation and reset.
module tb_crosswalk_btn_sync;

  logic       clk;
  logic       reset;
  logic       btn_raw;
  logic       ack;
  logic       busy;
  logic       req;
  logic       btn_level;
  logic       pending;
  logic [7:0] req_count;

  int n_chk;
  int n_fail;
  int exp_cnt;

  crosswalk_btn_sync #(
    .DEBOUNCE_CYCLES(4),
    .COUNT_W(8)
  ) dut (
    .i_clock    (clk),
    .i_reset    (reset),
    .i_btn_raw  (btn_raw),
    .i_ack      (ack),
    .i_busy     (busy),
    .o_req      (req),
    .o_btn_level(btn_level),
    .o_pending  (pending),
    .o_req_count(req_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset   = 1'b1;
    btn_raw = 1'b0;
    ack     = 1'b0;
    busy    = 1'b0;
    step(3);
    chk("rst_req", 32'(req), 0);
    chk("rst_level", 32'(btn_level), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_count", 32'(req_count), 0);
    reset = 1'b0;
    step(2);

    // glitch of 3 sampled cycles must be rejected
    btn_raw = 1'b1;
    step(3);
    btn_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("glitch_level", 32'(btn_level), 0);
      chk("glitch_req", 32'(req), 0);
    end
    chk("glitch_count", 32'(req_count), 0);

    // clean press: level rises exactly 5 edges after first sampling edge
    btn_raw = 1'b1;
    step(1);
    step(4);
    chk("deb_early_level", 32'(btn_level), 0);
    chk("deb_early_req", 32'(req), 0);
    step(1);
    chk("deb_level", 32'(btn_level), 1);
    chk("press_req", 32'(req), 1);
    chk("press_count", 32'(req_count), 1);

    // ack, busy not yet risen must not release WAIT, then busy fall -> IDLE
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("ack_req", 32'(req), 0);
    step(2);
    chk("wait_nobusy_req", 32'(req), 0);
    busy    = 1'b1;
    btn_raw = 1'b0;
    step(5);
    busy = 1'b0;
    step(1);
    chk("idle_req", 32'(req), 0);
    chk("idle_pending", 32'(pending), 0);
    step(3);

    // press from IDLE, then queued presses during busy
    btn_raw = 1'b1;
    step(6);
    chk("idle_press_req", 32'(req), 1);
    chk("idle_press_count", 32'(req_count), 2);
    ack = 1'b1;
    step(1);
    ack     = 1'b0;
    busy    = 1'b1;
    btn_raw = 1'b0;
    step(8);
    btn_raw = 1'b1;
    step(6);
    chk("queue_pending", 32'(pending), 1);
    chk("queue_req", 32'(req), 0);
    btn_raw = 1'b0;
    step(8);
    btn_raw = 1'b1;
    step(6);
    chk("queue2_pending", 32'(pending), 1);
    chk("queue2_count", 32'(req_count), 2);
    busy = 1'b0;
    step(1);
    chk("release_req", 32'(req), 1);
    chk("release_pending", 32'(pending), 0);
    chk("release_count", 32'(req_count), 3);
    ack = 1'b1;
    step(1);
    ack     = 1'b0;
    busy    = 1'b1;
    btn_raw = 1'b0;
    step(8);
    busy = 1'b0;
    step(2);
    chk("back_idle_req", 32'(req), 0);
    chk("back_idle_pending", 32'(pending), 0);

    // saturation over 300 cycles
    exp_cnt = 3;
    for (int i = 0; i < 300; i++) begin
      btn_raw = 1'b1;
      step(6);
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      chk("sat_req_hi", 32'(req), 1);
      chk("sat_count", 32'(req_count), 32'(exp_cnt));
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      chk("sat_req_lo", 32'(req), 0);
      busy    = 1'b1;
      btn_raw = 1'b0;
      step(8);
      busy = 1'b0;
      step(2);
    end
    chk("sat_final", 32'(req_count), 255);

    // reset with a queued press, button held through reset
    btn_raw = 1'b1;
    step(6);
    ack = 1'b1;
    step(1);
    ack     = 1'b0;
    busy    = 1'b1;
    btn_raw = 1'b0;
    step(8);
    btn_raw = 1'b1;
    step(6);
    chk("pre_rst_pending", 32'(pending), 1);
    reset = 1'b1;
    step(1);
    chk("mid_rst_req", 32'(req), 0);
    chk("mid_rst_pending", 32'(pending), 0);
    chk("mid_rst_level", 32'(btn_level), 0);
    chk("mid_rst_count", 32'(req_count), 0);
    reset = 1'b0;
    busy  = 1'b0;
    ack   = 1'b1;
    step(1);
    ack  = 1'b0;
    busy = 1'b1;
    chk("post_rst_e1_req", 32'(req), 0);
    step(2);
    busy = 1'b0;
    chk("post_rst_e3_req", 32'(req), 0);
    step(2);
    chk("post_rst_e5_req", 32'(req), 0);
    chk("post_rst_e5_level", 32'(btn_level), 0);
    step(1);
    chk("post_rst_e6_req", 32'(req), 1);
    chk("post_rst_e6_level", 32'(btn_level), 1);
    chk("post_rst_e6_count", 32'(req_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
